expr_checker: RTL and testbench

Streaming recogniser for arithmetic expression strings, one ASCII character per accepted cycle. It checks multi-digit operands, binary operators and parentheses nested up to a parametrised depth. It flags the current prefix as a complete, well-formed expression and holds a sticky error once the stream can no longer become valid. It sits between the character source and the expression evaluator, and replaces the single-digit recogniser used in earlier labs.

---
 rtl/expr_checker.sv | 105 ++++++++++
 tb/tb_expr_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_checker.sv
// expr_checker: streaming recogniser for digit/operator/parenthesis expressions; '-' is an operator only when EXPR_MINUS_EN is defined.
// Outputs are decoded from registers one edge after each accepted character; accepts one character per cycle and never stalls.
module expr_checker #(
   parameter int MAX_DIGITS = 4,
   parameter int DEPTH      = 3,
   parameter int CNT_W      = 8
) (
   input  logic                       clk,
   input  logic                       clr_n,
   input  logic                       restart,
   input  logic                       in_valid,
   input  logic [7:0]                 in,
   output logic                       out,
   output logic                       err,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic [CNT_W-1:0]           nops
);

   localparam int DW  = $clog2(DEPTH+1);
   localparam int DCW = $clog2(MAX_DIGITS+1);
   localparam logic [DW-1:0]  DEPTH_MAX = DW'(DEPTH);
   localparam logic [DCW-1:0] DCNT_MAX  = DCW'(MAX_DIGITS);

   typedef enum logic [1:0] {EXP_OPND, IN_NUM, AFT_CLOSE, ERR} state_t;

   state_t         state;
   logic [DCW-1:0] dcnt;
   logic           lz;

   logic is_digit;
   logic is_op;
   logic is_open;
   logic is_close;

   always_comb begin
      is_digit = (in >= 8'h30) && (in <= 8'h39);
      is_open  = (in == 8'h28);
      is_close = (in == 8'h29);
`ifdef EXPR_MINUS_EN
      is_op    = (in == 8'h2B) || (in == 8'h2A) || (in == 8'h2D);
`else
      is_op    = (in == 8'h2B) || (in == 8'h2A);
`endif
   end

   // depth and nops are only written on legal transitions, so they freeze on entry to ERR
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= EXP_OPND;
         depth <= '0;
         dcnt  <= '0;
         lz    <= 1'b0;
         nops  <= '0;
      end else if (restart) begin
         state <= EXP_OPND;
         depth <= '0;
         dcnt  <= '0;
         lz    <= 1'b0;
         nops  <= '0;
      end else if (in_valid) begin
         case (state)
            EXP_OPND: begin
               if (is_digit) begin
                  state <= IN_NUM;
                  dcnt  <= DCW'(1);
                  lz    <= (in == 8'h30);
               end else if (is_open && (depth < DEPTH_MAX)) begin
                  depth <= depth + 1'b1;
               end else begin
                  state <= ERR;
               end
            end
            IN_NUM: begin
               if (is_digit) begin
                  if (lz || (dcnt == DCNT_MAX)) state <= ERR;
                  else                          dcnt  <= dcnt + 1'b1;
               end else if (is_op) begin
                  state <= EXP_OPND;
                  if (nops != '1) nops <= nops + 1'b1;
               end else if (is_close && (depth != '0)) begin
                  state <= AFT_CLOSE;
                  depth <= depth - 1'b1;
               end else begin
                  state <= ERR;
               end
            end
            AFT_CLOSE: begin
               if (is_op) begin
                  state <= EXP_OPND;
                  if (nops != '1) nops <= nops + 1'b1;
               end else if (is_close && (depth != '0)) begin
                  depth <= depth - 1'b1;
               end else begin
                  state <= ERR;
               end
            end
            default: state <= ERR;
         endcase
      end
   end

   assign err = (state == ERR);
   assign out = ~err & ((state == IN_NUM) | (state == AFT_CLOSE)) & (depth == '0);

endmodule

// File: tb/tb_expr_checker.sv
// Randomised and directed bench for expr_checker; expected values come from re-scanning the accepted prefix.
module tb_expr_checker;

   localparam int MAXD = 4;
   localparam int DEP  = 3;
   localparam int CW   = 4;
   localparam int DW   = $clog2(DEP+1);
   localparam int NMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          clr_n = 1'b1;
   logic          restart = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in = 8'h00;
   logic          out;
   logic          err;
   logic [DW-1:0] depth;
   logic [CW-1:0] nops;

   int ntot  = 0;
   int npass = 0;
   bit chk_en = 1'b0;

   byte q[$];
   bit  exp_out;
   bit  exp_err;
   int  exp_depth;
   int  exp_nops;

   expr_checker #(.MAX_DIGITS(MAXD), .DEPTH(DEP), .CNT_W(CW)) dut (
      .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in),
      .out(out), .err(err), .depth(depth), .nops(nops)
   );

   always #5 clk = ~clk;

   function automatic bit is_op(input byte c);
`ifdef EXPR_MINUS_EN
      return (c == "+") || (c == "*") || (c == "-");
`else
      return (c == "+") || (c == "*");
`endif
   endfunction

   // Token-level scan of the whole prefix: 0 none, 1 operator, 2 '(', 3 digit, 4 ')'
   function automatic void model(input byte s[$], output bit o, output bit e, output int d, output int n);
      int prev;
      int run;
      bit lead0;
      prev = 0; run = 0; lead0 = 0; d = 0; n = 0; e = 0;
      foreach (s[i]) begin
         byte c;
         c = s[i];
         if (c >= "0" && c <= "9") begin
            if (prev == 3) begin
               if (lead0 || run == MAXD) e = 1;
               else run++;
            end else if (prev == 4) begin
               e = 1;
            end else begin
               run = 1;
               lead0 = (c == "0");
            end
            if (!e) prev = 3;
         end else if (is_op(c)) begin
            if (prev == 3 || prev == 4) begin
               prev = 1;
               if (n < NMAX) n++;
            end else e = 1;
         end else if (c == "(") begin
            if (prev <= 2 && d < DEP) begin
               d++;
               prev = 2;
            end else e = 1;
         end else if (c == ")") begin
            if ((prev == 3 || prev == 4) && d > 0) begin
               d--;
               prev = 4;
            end else e = 1;
         end else begin
            e = 1;
         end
         if (e) break;
      end
      o = !e && (prev == 3 || prev == 4) && d == 0;
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      ntot++;
      if (act == expv) npass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
   endtask

   task automatic refresh();
      model(q, exp_out, exp_err, exp_depth, exp_nops);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out", int'(out), int'(exp_out));
         chk("err", int'(err), int'(exp_err));
         chk("depth", int'(depth), exp_depth);
         chk("nops", int'(nops), exp_nops);
      end
   end

   task automatic step(input bit v, input byte c, input bit r);
      in_valid = v;
      in       = c;
      restart  = r;
      @(posedge clk);
      #1;
      if (r) q.delete();
      else if (v && !exp_err) q.push_back(c);
      refresh();
      in_valid = 1'b0;
      restart  = 1'b0;
   endtask

   task automatic send(input byte c);
      step(1'b1, c, 1'b0);
   endtask

   task automatic rs();
      step(1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      string s;
      int exp_o[7];
      int exp_d[7];
      #1 clr_n = 1'b0;
      #4;
      chk("rst_out", int'(out), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_depth", int'(depth), 0);
      chk("rst_nops", int'(nops), 0);
      #12 clr_n = 1'b1;
      refresh();
      chk_en = 1'b1;

      s = "12+3";
      exp_o = '{1, 1, 0, 1, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         send(s[i]);
         chk("seq1_out", int'(out), exp_o[i]);
      end
      chk("seq1_nops", int'(nops), 1);
      chk("seq1_err", int'(err), 0);

      rs();
      s = "((7)*4)";
      exp_d = '{1, 2, 2, 1, 1, 1, 0};
      for (int i = 0; i < 7; i++) begin
         send(s[i]);
         chk("nest_depth", int'(depth), exp_d[i]);
         chk("nest_out", int'(out), (i == 6) ? 1 : 0);
      end

      rs();
      for (int i = 0; i < 4; i++) send("(");
      chk("deep_err", int'(err), 1);
      chk("deep_depth", int'(depth), 3);
      send("5");
      chk("deep_err2", int'(err), 1);
      chk("deep_out", int'(out), 0);

      rs();
      send("0"); send("5");
      chk("lz_err", int'(err), 1);
      rs();
      s = "12345";
      for (int i = 0; i < 5; i++) begin
         send(s[i]);
         chk("len_err", int'(err), (i == 4) ? 1 : 0);
      end
      rs();
      send("0");
      chk("zero_out", int'(out), 1);

      rs();
      send("9"); send("-"); send("2");
`ifdef EXPR_MINUS_EN
      chk("minus_out", int'(out), 1);
      chk("minus_nops", int'(nops), 1);
`else
      chk("minus_err", int'(err), 1);
`endif

      send("x");
      chk("bad_err", int'(err), 1);
      step(1'b1, "8", 1'b1);
      chk("rsv_err", int'(err), 0);
      chk("rsv_out", int'(out), 0);
      chk("rsv_depth", int'(depth), 0);
      chk("rsv_nops", int'(nops), 0);
      send("8");
      chk("rsv_out2", int'(out), 1);

      rs();
      send("1"); send("+");
      for (int i = 0; i < 3; i++) step(1'b0, "(", 1'b0);
      chk("hold_depth", int'(depth), 0);
      chk("hold_nops", int'(nops), 1);
      send("2");
      chk("hold_out", int'(out), 1);

      rs();
      send("1");
      for (int i = 0; i < 20; i++) begin
         send("+"); send("1");
      end
      chk("sat_nops", int'(nops), NMAX);
      chk("sat_out", int'(out), 1);

      rs();
      send("("); send("3");
      #2 clr_n = 1'b0;
      #1;
      chk("arst_depth", int'(depth), 0);
      chk("arst_out", int'(out), 0);
      q.delete();
      refresh();
      #2 clr_n = 1'b1;
      send("4");
      chk("arst_out2", int'(out), 1);

      begin
         byte alpha[20];
         alpha = '{"0", "1", "2", "3", "5", "7", "9", "0", "1", "4",
                   "+", "*", "-", "+", "(", "(", ")", ")", " ", "a"};
         for (int i = 0; i < 4000; i++) begin
            bit v;
            bit r;
            v = ($urandom_range(0, 9) < 8);
            r = exp_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 2);
            step(v, alpha[$urandom_range(0, 19)], r);
         end
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
